// File: rtl/alu_result_skid_buffer.sv
// alu_result_skid_buffer
//
// Registered output stage behind the ALU subunits. Each accepted result is
// stored together with its 4-bit operation tag and a zero flag computed at
// capture time. Results are handed to the consumer over a valid/ready
// handshake. A two-entry skid buffer sustains one transfer per cycle, and
// in_ready is decoded from registered state only, so out_ready has no
// combinational path to in_ready.
//
// Ports:
//   clk               clock, rising edge
//   rst_n             asynchronous active-low reset
//   flush             synchronous discard of every buffered entry
//   in_valid          producer offers a result
//   in_ready          buffer can take a result this cycle
//   in_result         subunit result (OPD_LENGTH bits)
//   in_alu_op_select  operation tag travelling with the result
//   out_valid         out_* hold a valid entry
//   out_ready         consumer takes the entry this cycle
//   out_result        buffered result
//   out_alu_op_select buffered operation tag
//   out_zero          1 when out_result is zero (stored with the entry)
//   xfer_count        completed output transfers, wraps around

module alu_result_skid_buffer #(
    parameter int OPD_LENGTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [OPD_LENGTH-1:0] in_result,
    input  logic [3:0]            in_alu_op_select,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [OPD_LENGTH-1:0] out_result,
    output logic [3:0]            out_alu_op_select,
    output logic                  out_zero,
    output logic [CNT_WIDTH-1:0]  xfer_count
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    // Main entry (drives out_*) and skid entry.
    logic [OPD_LENGTH-1:0] m_result;
    logic [3:0]            m_op;
    logic                  m_zero;
    logic [OPD_LENGTH-1:0] s_result;
    logic [3:0]            s_op;
    logic                  s_zero;

    logic in_fire;
    logic out_fire;
    logic load_m_in;
    logic load_m_skid;
    logic load_s_in;
    logic in_zero;

    assign in_ready  = (state != FULL);
    assign out_valid = (state != EMPTY);
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;
    assign in_zero   = ~|in_result;

    assign out_result        = m_result;
    assign out_alu_op_select = m_op;
    assign out_zero          = m_zero;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        load_m_in   = 1'b0;
        load_m_skid = 1'b0;
        load_s_in   = 1'b0;
        if (flush) begin
            // Any accepted input this cycle is dropped; out_* keep their
            // last values and only the valid indication goes away.
            state_next = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_fire) begin
                        load_m_in  = 1'b1;
                        state_next = ONE;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        load_m_in = 1'b1;
                    end else if (in_fire) begin
                        load_s_in  = 1'b1;
                        state_next = FULL;
                    end else if (out_fire) begin
                        state_next = EMPTY;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        load_m_skid = 1'b1;
                        state_next  = ONE;
                    end
                end
                default: begin
                    state_next = EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_result <= '0;
            m_op     <= '0;
            m_zero   <= 1'b0;
        end else if (load_m_in) begin
            m_result <= in_result;
            m_op     <= in_alu_op_select;
            m_zero   <= in_zero;
        end else if (load_m_skid) begin
            m_result <= s_result;
            m_op     <= s_op;
            m_zero   <= s_zero;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_result <= '0;
            s_op     <= '0;
            s_zero   <= 1'b0;
        end else if (load_s_in) begin
            s_result <= in_result;
            s_op     <= in_alu_op_select;
            s_zero   <= in_zero;
        end
    end

    // Counts every output handshake, including one coinciding with flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xfer_count <= '0;
        end else if (out_fire) begin
            xfer_count <= xfer_count + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_alu_result_skid_buffer.sv
// Scoreboard bench for alu_result_skid_buffer. The reference is a bounded
// queue of capacity two: accepted results are pushed, delivered results are
// popped, flush empties it. A 4-bit counter width exercises wrap-around.

module tb_alu_result_skid_buffer;

    localparam int W  = 8;
    localparam int CW = 4;

    logic          clk;
    logic          rst_n;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_result;
    logic [3:0]    in_alu_op_select;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_result;
    logic [3:0]    out_alu_op_select;
    logic          out_zero;
    logic [CW-1:0] xfer_count;

    alu_result_skid_buffer #(.OPD_LENGTH(W), .CNT_WIDTH(CW)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .flush             (flush),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .in_result         (in_result),
        .in_alu_op_select  (in_alu_op_select),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_result        (out_result),
        .out_alu_op_select (out_alu_op_select),
        .out_zero          (out_zero),
        .xfer_count        (xfer_count)
    );

    typedef struct packed {
        logic [W-1:0] r;
        logic [3:0]   op;
        logic         z;
    } entry_t;

    entry_t exp_q[$];
    entry_t last_shown;
    entry_t exp_e;
    int     exp_cnt;
    int     checks;
    int     errors;
    bit     had_out;
    bit     in_ok;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a FIFO of depth two updated at each edge.
    initial begin
        last_shown = '0;
        exp_cnt    = 0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                exp_q.delete();
                exp_cnt    = 0;
                last_shown = '0;
            end else begin
                had_out = (exp_q.size() > 0) && out_ready;
                in_ok   = in_valid && (exp_q.size() < 2);
                if (had_out) exp_cnt = (exp_cnt + 1) % (1 << CW);
                if (flush) begin
                    exp_q.delete();
                end else begin
                    if (had_out) void'(exp_q.pop_front());
                    if (in_ok) exp_q.push_back('{r: in_result, op: in_alu_op_select,
                                                 z: (in_result == 0)});
                end
                if (exp_q.size() > 0) last_shown = exp_q[0];
            end
        end
    end

    // Monitor: compares DUT outputs against the head of the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            chk("out_valid", 32'(out_valid), 32'(exp_q.size() > 0));
            chk("in_ready", 32'(in_ready), 32'(exp_q.size() < 2));
            chk("xfer_count", 32'(xfer_count), 32'(exp_cnt));
            exp_e = (exp_q.size() > 0) ? exp_q[0] : last_shown;
            chk("out_result", 32'(out_result), 32'(exp_e.r));
            chk("out_op", 32'(out_alu_op_select), 32'(exp_e.op));
            chk("out_zero", 32'(out_zero), 32'(exp_e.z));
        end
    end

    task automatic step(input logic v, input logic [W-1:0] r, input logic [3:0] op,
                        input logic ordy, input logic fl);
        in_valid         = v;
        in_result        = r;
        in_alu_op_select = op;
        out_ready        = ordy;
        flush            = fl;
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        flush = 1'b0;
        in_valid = 1'b0;
        in_result = '0;
        in_alu_op_select = '0;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_result", 32'(out_result), 32'd0);
        step(0, 8'h00, 4'h0, 0, 0);
        step(0, 8'h00, 4'h0, 0, 0);

        // Streaming with out_ready held high
        step(1, 8'h01, 4'b0000, 1, 0);
        step(1, 8'h00, 4'b0001, 1, 0);
        step(1, 8'h01, 4'b0111, 1, 0);
        step(0, 8'h00, 4'h0, 1, 0);
        chk("stream_count", 32'(xfer_count), 32'd3);

        // Backpressure: fill, refuse third push, then drain
        step(1, 8'h01, 4'b0010, 0, 0);
        step(1, 8'h00, 4'b0110, 0, 0);
        chk("bp_full_ready", 32'(in_ready), 32'd0);
        step(1, 8'hff, 4'b1111, 0, 0);
        step(0, 8'h00, 4'h0, 0, 0);
        chk("bp_hold_result", 32'(out_result), 32'h01);
        step(0, 8'h00, 4'h0, 1, 0);
        chk("bp_ready_back", 32'(in_ready), 32'd1);
        step(0, 8'h00, 4'h0, 1, 0);
        step(0, 8'h00, 4'h0, 0, 0);

        // Simultaneous push and pop in ONE
        step(1, 8'h01, 4'b0011, 0, 0);
        step(1, 8'h00, 4'b0100, 1, 0);
        chk("pushpop_result", 32'(out_result), 32'h00);
        step(0, 8'h00, 4'h0, 1, 0);

        // Flush while FULL with a pending input
        step(1, 8'h05, 4'h1, 0, 0);
        step(1, 8'h06, 4'h1, 0, 0);
        step(1, 8'h07, 4'h1, 0, 1);
        chk("flush_valid", 32'(out_valid), 32'd0);
        step(0, 8'h00, 4'h0, 1, 0);
        step(0, 8'h00, 4'h0, 1, 0);

        // Asynchronous reset pulse while FULL
        step(1, 8'h09, 4'h5, 0, 0);
        step(1, 8'h0a, 4'h6, 0, 0);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("areset_out_valid", 32'(out_valid), 32'd0);
        chk("areset_count", 32'(xfer_count), 32'd0);
        chk("areset_result", 32'(out_result), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Counter wrap: 17 output transfers on a 4-bit counter
        for (int i = 0; i < 17; i++) step(1, 8'(i + 1), 4'(i), 1, 0);
        step(0, 8'h00, 4'h0, 1, 0);
        chk("wrap_count", 32'(xfer_count), 32'd1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 9) < 7),
                 ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom),
                 4'($urandom),
                 ($urandom_range(0, 9) < 6),
                 ($urandom_range(0, 99) < 3));
        end
        step(0, 8'h00, 4'h0, 1, 0);
        step(0, 8'h00, 4'h0, 1, 0);
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
